// File: rtl/shift_unit.sv
// Iterative one-bit-per-cycle shifter for the EX stage.
// Handles SLL/SRL/SRA behind valid/ready handshakes and reports busy to hazard logic.
module shift_unit #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] data_a,
  input  logic [31:0]       shamt_ext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_work;
  logic [AMT_W-1:0]    r_cnt;
  logic [1:0]          r_op;

  logic [DATA_W-1:0]   w_shifted;
  logic [AMT_W-1:0]    w_amt;
  logic                w_unused_amt;

  assign w_amt        = shamt_ext[AMT_W-1:0];
  assign w_unused_amt = ^shamt_ext[31:AMT_W];

  // One-bit step of the working value; reserved op 10 falls back to SLL
  always_comb begin
    w_shifted = {r_work[DATA_W-2:0], 1'b0};
    unique case (1'b1)
      (r_op == 2'b01): w_shifted = {1'b0, r_work[DATA_W-1:1]};
      (r_op == 2'b11): w_shifted = {r_work[DATA_W-1], r_work[DATA_W-1:1]};
      default:         w_shifted = {r_work[DATA_W-2:0], 1'b0};
    endcase
  end

  // Control FSM and datapath; flush overrides every other request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_op    <= 2'b00;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work  <= data_a;
            r_op    <= op;
            r_cnt   <= w_amt;
            r_state <= (w_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign result    = r_work;

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit.
// Scenario tasks run in order from one initial block.
module tb_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] data_a;
  logic [31:0] shamt_ext;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks;
  int errors;

  shift_unit #(.DATA_W(32), .AMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_a    (data_a),
    .shamt_ext (shamt_ext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; returns edges after accept
  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] s, output int lat);
    @(negedge clk);
    op = o; data_a = a; shamt_ext = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== 32'h0) begin
      errors++;
      $display("FAIL reset: rdy=%b ov=%b busy=%b res=%h want 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_sll();
    int lat;
    issue(2'b00, 32'h0000_0001, 32'd4, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL sll_latency: got %0d want 4", lat);
    end
    checks++;
    if (result !== 32'h0000_0010) begin
      errors++;
      $display("FAIL sll_result: got %h want 00000010", result);
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sll_release: rdy=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_sra_srl_max();
    int lat;
    issue(2'b11, 32'h8000_0000, 32'd31, lat);
    checks++;
    if (lat !== 31 || result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sra31: lat=%0d res=%h want 31 ffffffff", lat, result);
    end
    release_result();
    issue(2'b01, 32'h8000_0000, 32'd31, lat);
    checks++;
    if (lat !== 31 || result !== 32'h0000_0001) begin
      errors++;
      $display("FAIL srl31: lat=%0d res=%h want 31 00000001", lat, result);
    end
    release_result();
  endtask

  task automatic test_zero_shift();
    int lat;
    issue(2'b01, 32'hDEAD_BEEF, 32'd0, lat);
    checks++;
    if (lat !== 0 || result !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL zero_shift: lat=%0d res=%h want 0 deadbeef", lat, result);
    end
    release_result();
  endtask

  task automatic test_reserved_op();
    int lat;
    issue(2'b10, 32'h0000_0003, 32'd2, lat);
    checks++;
    if (lat !== 2 || result !== 32'h0000_000C) begin
      errors++;
      $display("FAIL reserved_op: lat=%0d res=%h want 2 0000000c", lat, result);
    end
    release_result();
    issue(2'b11, 32'h4000_0000, 32'd3, lat);
    checks++;
    if (result !== 32'h0800_0000) begin
      errors++;
      $display("FAIL sra_positive: got %h want 08000000", result);
    end
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    issue(2'b00, 32'h0000_00A5, 32'd1, lat);
    checks++;
    if (lat !== 1 || result !== 32'h0000_014A) begin
      errors++;
      $display("FAIL hold_first: lat=%0d res=%h want 1 0000014a", lat, result);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      op = 2'b01; data_a = 32'h1234_5678 + i; shamt_ext = 32'd2;
      in_valid = i[0];
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'h0000_014A ||
          in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable: %0d bad cycles want 0 (ov=%b res=%h rdy=%b)",
               bad, out_valid, result, in_ready);
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_queue: rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    @(negedge clk);
    op = 2'b00; data_a = 32'h0000_00FF; shamt_ext = 32'd8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: rdy=%b busy=%b ov=%b want 1 0 0",
               in_ready, busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_no_result: out_valid seen %0d want 0", seen);
    end
    flush = 1'b1; in_valid = 1'b1; data_a = 32'h1; shamt_ext = 32'd3;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept: rdy=%b busy=%b want 1 0",
               in_ready, busy);
    end
    issue(2'b01, 32'hF000_0000, 32'd8, lat);
    checks++;
    if (lat !== 8 || result !== 32'h00F0_0000) begin
      errors++;
      $display("FAIL flush_next_op: lat=%0d res=%h want 8 00f00000", lat, result);
    end
    release_result();
  endtask

  task automatic test_input_change();
    int lat;
    @(negedge clk);
    op = 2'b11; data_a = 32'hF000_0000; shamt_ext = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op = 2'b00; data_a = 32'h0; shamt_ext = 32'd0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || result !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL input_change: lat=%0d res=%h want 4 ff000000", lat, result);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b00, 32'h0000_0001, 32'd1, lat);
    out_ready = 1'b1;
    op = 2'b01; data_a = 32'h0000_0100; shamt_ext = 32'd4;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || result !== 32'h0000_0010) begin
      errors++;
      $display("FAIL back_to_back: lat=%0d res=%h want 4 00000010", lat, result);
    end
    release_result();
  endtask

  task automatic test_async_reset();
    int lat;
    @(negedge clk);
    op = 2'b00; data_a = 32'h0000_0003; shamt_ext = 32'd10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b ov=%b busy=%b res=%h want 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'h0000_0001, 32'hFFFF_FFE3, lat);
    checks++;
    if (lat !== 3 || result !== 32'h0000_0008) begin
      errors++;
      $display("FAIL amt_mask: lat=%0d res=%h want 3 00000008", lat, result);
    end
    release_result();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    data_a = '0;
    shamt_ext = '0;
    test_reset();
    test_sll();
    test_sra_srl_max();
    test_zero_shift();
    test_reserved_op();
    test_hold();
    test_flush();
    test_input_change();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
